// File: rtl/logic_unit_pkg.sv
// Shared constants for the logic unit arbiter cluster.
// Opcodes and sequencer state encoding.
package logic_unit_pkg;

  typedef logic [1:0] opcode_t;

  localparam opcode_t OP_AND  = 2'b00;
  localparam opcode_t OP_OR   = 2'b01;
  localparam opcode_t OP_NOT  = 2'b10;
  localparam opcode_t OP_RSVD = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Requester-side bundle for the shared logic unit.
// master drives requests, slave is the arbiter.
interface logic_unit_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);

  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] a;
  logic [WIDTH*NREQ-1:0] b;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      result;
  logic                  err;
  logic                  busy;

  modport master (
    output req, op, a, b,
    input  grant, done, result, err, busy
  );

  modport slave (
    input  req, op, a, b,
    output grant, done, result, err, busy
  );

endinterface

// File: rtl/bitwise_logic_unit.sv
// Combinational AND / OR / NOT datapath.
// Reserved opcode yields zero and flags err.
module bitwise_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  opcode_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit.
// IDLE picks a winner, EXEC computes, DONE pulses done.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  logic_unit_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  logic [1:0]       state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    pick;
  logic [IW-1:0]    next_ptr;
  logic             found;
  opcode_t          op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] alu_y;
  logic             alu_err;
  logic [WIDTH-1:0] result_q;
  logic             err_q;

  // first set req at or above rr_ptr, wrapping
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req[(int'(rr_ptr) + k) % NREQ]) begin
        found = 1'b1;
        pick  = IW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign next_ptr = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;

  bitwise_logic_unit #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y),
    .err(alu_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      idx      <= '0;
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            idx   <= pick;
            op_q  <= bus.op[2*int'(pick) +: 2];
            a_q   <= bus.a[WIDTH*int'(pick) +: WIDTH];
            b_q   <= bus.b[WIDTH*int'(pick) +: WIDTH];
            state <= EXEC;
          end
        end
        EXEC: begin
          result_q <= alu_y;
          err_q    <= alu_err;
          state    <= DONE;
        end
        DONE: begin
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.grant = '0;
    bus.done  = '0;
    if (state == EXEC) bus.grant[idx] = 1'b1;
    if (state == DONE) bus.done[idx]  = 1'b1;
  end

  assign bus.busy   = (state == EXEC) || (state == DONE);
  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one WIDTH-bit bitwise logic unit (AND / OR / NOT) among NREQ requesters.
- Round-robin arbitration, a registered three-state sequencer, and a per-requester done pulse carrying the result.
- Sits between the block-level requesters and the behavioural gate datapath, so one gate unit serves the whole cluster.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand and result width in bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  request per requester; held high until the matching done pulse.
- op  input  2*NREQ  opcode per requester, slice i = op[2i+1:2i]; 00 AND, 01 OR, 10 NOT a, 11 reserved.
- a  input  WIDTH*NREQ  operand A per requester, slice i = a[WIDTH*i +: WIDTH].
- b  input  WIDTH*NREQ  operand B per requester; ignored for NOT.
- grant  output  NREQ  one-hot; high during EXEC for the owning requester.
- done  output  NREQ  one-hot, single-cycle pulse in DONE for the owning requester.
- result  output  WIDTH  operation result; valid while done is nonzero, held otherwise.
- err  output  1  high with done when the latched opcode was 11.
- busy  output  1  high in EXEC and DONE.

Behaviour:
- Reset (async assert, removed synchronously to clk):
  - state=IDLE, rr_ptr=0.
  - grant=0, done=0, result=0, err=0, busy=0.
  - Latched operands/opcode cleared.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set req bit, searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - Latch the winner's index, op, a and b; go to EXEC.
- EXEC (1 cycle):
  - grant[idx]=1, busy=1.
  - The logic unit evaluates the latched operands.
  - The result is registered into result; err = (latched op==11).
  - Go to DONE.
- DONE (1 cycle):
  - done[idx]=1, busy=1, grant=0.
  - rr_ptr = (idx+1) mod NREQ.
  - Go to IDLE.
- Latency: req seen in IDLE at edge N; grant visible in cycle N+1; done/result in cycle N+2. Back-to-back throughput is one operation per 3 cycles.
- Arithmetic:
  - AND = a&b; OR = a|b; NOT = ~a, b ignored.
  - Reserved opcode 11 gives result=0 and err=1.
- Operands are latched at grant. Changes to a, b, op or req after the IDLE decision do not affect the operation in flight.
- A req dropped during EXEC/DONE does not abort: done still pulses and the result still updates.
- Requester i must deassert req in the cycle after its done pulse, or it competes again. It is then lowest priority because rr_ptr has moved past it.
- result and err hold their last values outside DONE. Benches check them only when done is nonzero.
- Simultaneous requests: exactly one grant. Any requester with req held continuously is served within NREQ operations (no starvation).
- rr_ptr wrap: idx=NREQ-1 gives rr_ptr=0.
- Reset asserted in EXEC or DONE: immediate return to reset values. No done pulse for the aborted operation; requesters must re-request.
- grant and done are never nonzero in the same cycle.
- grant, done and busy are all zero in IDLE.

Decomposition:
- Shared package logic_unit_pkg:
  - Opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_NOT=2'b10, OP_RSVD=2'b11.
  - State encoding IDLE=2'd0, EXEC=2'd1, DONE=2'd2.
- Sub-module bitwise_logic_unit: combinational, WIDTH-parameterised AND/OR/NOT mux with an err output for opcode 11. Instantiated once, fed from the latched operands.
- Round-robin priority search stays inline in logic_unit_arbiter.

Test Plan:
- Reset, then req=0001, op0=00, a0=8'hF0, b0=8'h3C → grant=0001 next cycle; done=0001 with result=8'h30, err=0 the cycle after.
- All four req high, ops AND/OR/NOT/AND with distinct operands, each req held until its done → done order 0001, 0010, 0100, 1000, then 0001 again. Results per op are correct; NOT with a2=8'hA5 gives 8'h5A.
- req1 held high continuously alongside req0 and req3 (also held high) → req1 served within 4 operations; rr_ptr wraps from 3 to 0 correctly.
- Opcode 11 from requester 2 → done=0100, result=8'h00, err=1. The next legal operation gives err=0.
- Change a0 from 8'hFF to 8'h00 during EXEC, with op0=01 and b0=8'h00 → result=8'hFF from the latched operands. Dropping req0 in EXEC still produces the done pulse.
- Assert rst in EXEC → grant, done and busy go to 0 immediately with no done pulse. After release, a pending req3 with rr_ptr=0 and req0 also high → requester 0 is granted first.
